// File: rtl/fixed_stream_argmax.sv
// Streaming signed argmax over a frame of IN_DEPTH beats of IN_SIZE lanes each.
// The frame result is held under a valid/ready handshake until the consumer accepts it.
module fixed_stream_argmax #(
  parameter int IN_WIDTH  = 32,
  parameter int IN_SIZE   = 4,
  parameter int IN_DEPTH  = 3,
  parameter int IDX_WIDTH = (IN_SIZE * IN_DEPTH > 1) ? $clog2(IN_SIZE * IN_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE-1:0],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [IDX_WIDTH-1:0] max_index,
  output logic [IN_WIDTH-1:0]  max_value,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam int LANE_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int BEAT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IN_DEPTH - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [BEAT_W-1:0]    beat_cnt_r;
  logic [IN_WIDTH-1:0]  max_value_r;
  logic [IDX_WIDTH-1:0] max_index_r;
  logic [IN_WIDTH-1:0]  win_val_s;
  logic [LANE_W-1:0]    win_lane_s;
  logic [31:0]          cand_idx_s;
  logic                 accept_s;
  logic                 last_beat_s;
  logic                 take_s;

  // In-beat winner: strict compare while scanning upward keeps the lowest lane on ties.
  always_comb begin
    win_val_s  = data_in[0];
    win_lane_s = '0;
    for (int i = 1; i < IN_SIZE; i++) begin
      if ($signed(data_in[i]) > $signed(win_val_s)) begin
        win_val_s  = data_in[i];
        win_lane_s = LANE_W'(i);
      end else begin
        win_val_s  = win_val_s;
        win_lane_s = win_lane_s;
      end
    end
  end

  // Handshake qualifiers and the running-max update decision.
  always_comb begin
    accept_s    = data_in_valid && data_in_ready;
    last_beat_s = (beat_cnt_r == LAST_BEAT);
    cand_idx_s  = 32'(beat_cnt_r) * 32'(IN_SIZE) + 32'(win_lane_s);
    if (beat_cnt_r == '0) begin
      take_s = accept_s;
    end else begin
      take_s = accept_s && ($signed(win_val_s) > $signed(max_value_r));
    end
  end

  // Next-state and handshake outputs decoded from the state register only.
  always_comb begin
    state_next_s   = state_r;
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    case (state_r)
      ACCUM: begin
        data_in_ready = 1'b1;
        if (data_in_valid && last_beat_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE: begin
        data_out_valid = 1'b1;
        if (data_out_ready) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Beat counter: wraps on the last accepted beat and is forced clear when the result drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= '0;
    end else if (accept_s) begin
      beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BEAT_W'(1);
    end else if ((state_r == DONE) && data_out_ready) begin
      beat_cnt_r <= '0;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Running max and its frame position.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_value_r <= '0;
      max_index_r <= '0;
    end else if (take_s) begin
      max_value_r <= win_val_s;
      max_index_r <= cand_idx_s[IDX_WIDTH-1:0];
    end else begin
      max_value_r <= max_value_r;
      max_index_r <= max_index_r;
    end
  end

  assign max_value = max_value_r;
  assign max_index = max_index_r;

endmodule

// File: tb/tb_fixed_stream_argmax.sv
// Self-checking bench for fixed_stream_argmax (8-bit, 4 lanes, 3 beats): directed table,
// handshake corner sequences and random frames against a first-occurrence argmax model.
module tb_fixed_stream_argmax;

  localparam int W = 8;
  localparam int S = 4;
  localparam int D = 3;
  localparam int N = S * D;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in [S-1:0];
  logic          data_in_valid;
  logic          data_in_ready;
  logic [IW-1:0] max_index;
  logic [W-1:0]  max_value;
  logic          data_out_valid;
  logic          data_out_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string name;
    int    v [N];
    int    exp_idx;
    int    exp_val;
  } vec_t;

  vec_t tbl [6];

  fixed_stream_argmax #(
    .IN_WIDTH(W), .IN_SIZE(S), .IN_DEPTH(D), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .max_index(max_index), .max_value(max_value),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_argmax(input int v [N], output int idx, output int val);
    idx = 0;
    val = v[0];
    for (int i = 1; i < N; i++) begin
      if (v[i] > val) begin
        idx = i;
        val = v[i];
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", int'(data_in_ready), 1);
    chk("rst_out_valid", int'(data_out_valid), 0);
    chk("rst_index", int'(max_index), 0);
    chk("rst_value", int'($signed(max_value)), 0);
  endtask

  // Offers one beat, with random idle cycles (random junk data) until it is accepted.
  task automatic send_beat(input int v [N], input int b, input int idle_pct);
    int  guard;
    bit  acc;
    guard = 0;
    forever begin
      if (int'($urandom_range(99)) < idle_pct) begin
        data_in_valid = 1'b0;
        for (int i = 0; i < S; i++) data_in[i] = W'($urandom_range(255));
      end else begin
        data_in_valid = 1'b1;
        for (int i = 0; i < S; i++) data_in[i] = W'(v[b * S + i]);
      end
      acc = data_in_valid && data_in_ready;
      tick();
      if (acc) break;
      guard++;
      if (guard > 200) begin
        chk("beat_accept_timeout", 0, 1);
        break;
      end
    end
    data_in_valid = 1'b0;
  endtask

  task automatic send_frame(input int v [N], input int idle_pct);
    for (int b = 0; b < D; b++) begin
      if (b == D - 1) chk("valid_low_before_last", int'(data_out_valid), 0);
      send_beat(v, b, idle_pct);
    end
  endtask

  task automatic check_result(input string name, input int ei, input int ev);
    chk({name, "_valid"}, int'(data_out_valid), 1);
    chk({name, "_in_ready"}, int'(data_in_ready), 0);
    chk({name, "_index"}, int'(max_index), ei);
    chk({name, "_value"}, int'($signed(max_value)), ev);
  endtask

  // Holds the result for `hold` cycles with junk beats offered, then drains it.
  task automatic consume(input int hold, input int ei, input int ev);
    for (int h = 0; h < hold; h++) begin
      data_in_valid = 1'b1;
      for (int i = 0; i < S; i++) data_in[i] = W'($urandom_range(255));
      tick();
      check_result("hold", ei, ev);
    end
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    chk("drain_valid", int'(data_out_valid), 0);
    chk("drain_in_ready", int'(data_in_ready), 1);
  endtask

  initial begin
    int v [N];
    int ei, ev;
    int first_k, n_valid, last_k;

    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    for (int i = 0; i < S; i++) data_in[i] = '0;

    tbl[0].name = "mixed";    tbl[0].v = '{1, 2, 3, 4, 5, 9, 7, 0, -1, -2, -3, -4};
    tbl[0].exp_idx = 5;       tbl[0].exp_val = 9;
    tbl[1].name = "negative"; tbl[1].v = '{-8, -7, -9, -10, -5, -6, -4, -20, -3, -128, -3, -9};
    tbl[1].exp_idx = 8;       tbl[1].exp_val = -3;
    tbl[2].name = "all_five"; tbl[2].v = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    tbl[2].exp_idx = 0;       tbl[2].exp_val = 5;
    tbl[3].name = "all_min";  tbl[3].v = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    tbl[3].exp_idx = 0;       tbl[3].exp_val = -128;
    tbl[4].name = "last_max"; tbl[4].v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
    tbl[4].exp_idx = 11;      tbl[4].exp_val = 127;
    tbl[5].name = "late_tie"; tbl[5].v = '{-1, 3, -2, 0, 2, 1, 3, 3, 4, 0, 4, -5};
    tbl[5].exp_idx = 8;       tbl[5].exp_val = 4;

    do_reset();

    // Directed table, back-to-back beats.
    for (int t = 0; t < 6; t++) begin
      send_frame(tbl[t].v, 0);
      check_result(tbl[t].name, tbl[t].exp_idx, tbl[t].exp_val);
      consume(0, tbl[t].exp_idx, tbl[t].exp_val);
    end

    // Stalled consumer for 5 cycles, then the next frame.
    v = '{1, 2, 3, 4, 5, 9, 7, 0, -1, -2, -3, -4};
    send_frame(v, 0);
    consume(5, 5, 9);
    v = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(v, 0);
    check_result("after_stall", 3, 1);
    consume(0, 3, 1);

    // Reset after two beats discards the partial frame.
    v = '{0, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_beat(v, 0, 0);
    send_beat(v, 1, 0);
    do_reset();
    v = '{1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    send_frame(v, 0);
    check_result("post_reset", 5, 2);

    // Reset while holding a result drops it.
    do_reset();

    // Throughput: continuous valid and ready gives a result every D+1 cycles.
    for (int i = 0; i < S; i++) data_in[i] = '0;
    data_in_valid = 1'b1;
    data_out_ready = 1'b1;
    first_k = -1;
    last_k = -1;
    n_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (data_out_valid) begin
        n_valid++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
    end
    chk("tput_count", n_valid, 2);
    chk("tput_first", first_k, D);
    chk("tput_period", last_k - first_k, D + 1);
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    do_reset();

    // Random frames with idle gaps against the reference model.
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(1) == 1) v[i] = int'($urandom_range(255)) - 128;
        else v[i] = int'($urandom_range(6)) - 3;
      end
      ref_argmax(v, ei, ev);
      send_frame(v, 60);
      check_result("random", ei, ev);
      consume(int'($urandom_range(3)), ei, ev);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
